cam_array: RTL and testbench



---
 rtl/cam_pkg.sv | 24 ++
 rtl/cam_prio_enc.sv | 30 +++
 rtl/cam_array.sv | 147 ++++++++++++++
 tb/tb_cam_array.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cam_pkg.sv
// rtl/cam_pkg.sv - shared constants and helpers for the cam_array block
//
// Purpose: address-width helper and parameter legality limits used by the
//          cam_array assertions.
// Contents: cam_clog2(n) - ceil(log2(n)), returns 0 for n <= 1
//           WIDTH_MIN, DEPTH_MIN - smallest legal entry width / depth
package cam_pkg;

   localparam int WIDTH_MIN = 1;
   localparam int DEPTH_MIN = 2;

   function automatic int cam_clog2(input int n);
      int r;
      int v;
      r = 0;
      v = n - 1;
      while (v > 0) begin
         r = r + 1;
         v = v >> 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/cam_prio_enc.sv
// rtl/cam_prio_enc.sv - lowest-index priority encoder for the CAM match vector
//
// Purpose: purely combinational; picks the lowest set bit of vec.
// Ports:   vec  in  DEPTH  per-entry match bits
//          addr out AW     index of lowest set bit, 0 when vec == 0
//          any  out 1      OR of vec
module cam_prio_enc
   import cam_pkg::*;
#(
   parameter int DEPTH = 8,
   localparam int AW = cam_clog2(DEPTH)
) (
   input  logic [DEPTH-1:0] vec,
   output logic [AW-1:0]    addr,
   output logic             any
);

   // Scan from the top down so the lowest set index is the last assignment.
   always_comb begin
      addr = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (vec[i]) begin
            addr = AW'(i);
         end
      end
   end

   assign any = |vec;

endmodule

// File: rtl/cam_array.sv
// rtl/cam_array.sv - DEPTH x WIDTH ternary-search CAM with write/invalidate/read/search ports
//
// Purpose: flat register storage with per-entry valid bits, a 1-cycle read
//          path and a 2-stage masked search pipeline with lowest-index
//          priority encoding.
// Ports:   CLK, RST (sync, active-high)
//          WR_EN/WR_ADDR/WR_DATA        write entry, set valid
//          INV_EN/INV_ADDR              clear valid (write wins on same address)
//          RD_EN/RD_ADDR -> RD_DATA/RD_HIT/RD_VALID           1-cycle read
//          SRCH_EN/SRCH_KEY/SRCH_MASK -> MATCH_VEC/MATCH/MATCH_ADDR/MATCH_VALID
//                                                             2-cycle search
module cam_array
   import cam_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int DEPTH = 8,
   parameter int AW    = cam_clog2(DEPTH)
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             WR_EN,
   input  logic [AW-1:0]    WR_ADDR,
   input  logic [WIDTH-1:0] WR_DATA,
   input  logic             INV_EN,
   input  logic [AW-1:0]    INV_ADDR,
   input  logic             RD_EN,
   input  logic [AW-1:0]    RD_ADDR,
   output logic [WIDTH-1:0] RD_DATA,
   output logic             RD_HIT,
   output logic             RD_VALID,
   input  logic             SRCH_EN,
   input  logic [WIDTH-1:0] SRCH_KEY,
   input  logic [WIDTH-1:0] SRCH_MASK,
   output logic [DEPTH-1:0] MATCH_VEC,
   output logic             MATCH,
   output logic [AW-1:0]    MATCH_ADDR,
   output logic             MATCH_VALID
);

   localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

   logic [WIDTH-1:0] entry [DEPTH];
   logic [DEPTH-1:0] valid;

   logic             wr_ok;
   logic             inv_ok;
   logic             rd_ok;
   logic [DEPTH-1:0] cmp_vec;
   logic             s1_valid;
   logic [DEPTH-1:0] s1_vec;
   logic [AW-1:0]    enc_addr;
   logic             enc_any;

   // Addresses at or above DEPTH only exist when DEPTH is not a power of two.
   assign wr_ok  = ({1'b0, WR_ADDR}  < DEPTH_W);
   assign inv_ok = ({1'b0, INV_ADDR} < DEPTH_W);
   assign rd_ok  = ({1'b0, RD_ADDR}  < DEPTH_W);

   // Invalidate is applied before write so a same-address pair leaves the
   // entry valid.
   always_ff @(posedge CLK) begin
      if (RST) begin
         valid <= '0;
      end else begin
         if (INV_EN && inv_ok) begin
            valid[INV_ADDR] <= 1'b0;
         end
         if (WR_EN && wr_ok) begin
            valid[WR_ADDR] <= 1'b1;
         end
      end
   end

   // Entry data is deliberately not reset; the valid bits gate its use.
   always_ff @(posedge CLK) begin
      if (!RST && WR_EN && wr_ok) begin
         entry[WR_ADDR] <= WR_DATA;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         RD_DATA  <= '0;
         RD_HIT   <= 1'b0;
         RD_VALID <= 1'b0;
      end else begin
         RD_VALID <= RD_EN;
         if (RD_EN) begin
            if (rd_ok) begin
               RD_DATA <= entry[RD_ADDR];
               RD_HIT  <= valid[RD_ADDR];
            end else begin
               RD_DATA <= '0;
               RD_HIT  <= 1'b0;
            end
         end
      end
   end

   always_comb begin
      cmp_vec = '0;
      for (int i = 0; i < DEPTH; i++) begin
         cmp_vec[i] = valid[i] && (((entry[i] ^ SRCH_KEY) & SRCH_MASK) == '0);
      end
   end

   // Stage 1 holds its match vector while idle so the match lines stay quiet.
   always_ff @(posedge CLK) begin
      if (RST) begin
         s1_valid <= 1'b0;
         s1_vec   <= '0;
      end else begin
         s1_valid <= SRCH_EN;
         if (SRCH_EN) begin
            s1_vec <= cmp_vec;
         end
      end
   end

   cam_prio_enc #(
      .DEPTH (DEPTH)
   ) u_prio_enc (
      .vec  (s1_vec),
      .addr (enc_addr),
      .any  (enc_any)
   );

   always_ff @(posedge CLK) begin
      if (RST) begin
         MATCH_VEC   <= '0;
         MATCH       <= 1'b0;
         MATCH_ADDR  <= '0;
         MATCH_VALID <= 1'b0;
      end else begin
         MATCH_VALID <= s1_valid;
         if (s1_valid) begin
            MATCH_VEC  <= s1_vec;
            MATCH      <= enc_any;
            MATCH_ADDR <= enc_addr;
         end
      end
   end

   a_width_legal: assert property (@(posedge CLK) WIDTH >= WIDTH_MIN);
   a_depth_legal: assert property (@(posedge CLK) DEPTH >= DEPTH_MIN);

endmodule

// File: tb/tb_cam_array.sv
// tb/tb_cam_array.sv - scoreboard testbench for cam_array
module tb_cam_array;

   logic       CLK;
   logic       RST;
   logic       WR_EN;
   logic [2:0] WR_ADDR;
   logic [3:0] WR_DATA;
   logic       INV_EN;
   logic [2:0] INV_ADDR;
   logic       RD_EN;
   logic [2:0] RD_ADDR;
   logic [3:0] RD_DATA;
   logic       RD_HIT;
   logic       RD_VALID;
   logic       SRCH_EN;
   logic [3:0] SRCH_KEY;
   logic [3:0] SRCH_MASK;
   logic [7:0] MATCH_VEC;
   logic       MATCH;
   logic [2:0] MATCH_ADDR;
   logic       MATCH_VALID;

   cam_array #(
      .WIDTH (4),
      .DEPTH (8)
   ) dut (
      .CLK         (CLK),
      .RST         (RST),
      .WR_EN       (WR_EN),
      .WR_ADDR     (WR_ADDR),
      .WR_DATA     (WR_DATA),
      .INV_EN      (INV_EN),
      .INV_ADDR    (INV_ADDR),
      .RD_EN       (RD_EN),
      .RD_ADDR     (RD_ADDR),
      .RD_DATA     (RD_DATA),
      .RD_HIT      (RD_HIT),
      .RD_VALID    (RD_VALID),
      .SRCH_EN     (SRCH_EN),
      .SRCH_KEY    (SRCH_KEY),
      .SRCH_MASK   (SRCH_MASK),
      .MATCH_VEC   (MATCH_VEC),
      .MATCH       (MATCH),
      .MATCH_ADDR  (MATCH_ADDR),
      .MATCH_VALID (MATCH_VALID)
   );

   typedef struct packed {
      logic       rst;
      logic       wr_en;
      logic [2:0] wa;
      logic [3:0] wd;
      logic       inv_en;
      logic [2:0] ia;
      logic       rd_en;
      logic [2:0] ra;
      logic       s_en;
      logic [3:0] key;
      logic [3:0] mask;
   } op_t;

   typedef struct {
      int         due;
      logic [7:0] vec;
      logic       m;
      logic [2:0] addr;
   } sexp_t;

   typedef struct {
      int         due;
      logic [3:0] d;
      logic       h;
   } rexp_t;

   sexp_t      sq[$];
   rexp_t      rq[$];
   logic [3:0] mdata [8];
   logic [7:0] mvalid;
   int         cyc;
   int         checks;
   int         failures;

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   initial cyc = 0;
   always @(posedge CLK) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h cyc=%0d", tag, got, exp, cyc);
      end
   endtask

   // One cycle of stimulus; expectations come from the pre-update model.
   task automatic issue(input op_t o);
      sexp_t se;
      rexp_t re;
      @(posedge CLK);
      #1;
      RST       = o.rst;
      WR_EN     = o.wr_en;
      WR_ADDR   = o.wa;
      WR_DATA   = o.wd;
      INV_EN    = o.inv_en;
      INV_ADDR  = o.ia;
      RD_EN     = o.rd_en;
      RD_ADDR   = o.ra;
      SRCH_EN   = o.s_en;
      SRCH_KEY  = o.key;
      SRCH_MASK = o.mask;
      if (o.rst) begin
         while (sq.size() > 0 && sq[$].due > cyc) void'(sq.pop_back());
         while (rq.size() > 0 && rq[$].due > cyc) void'(rq.pop_back());
         mvalid = '0;
      end else begin
         if (o.s_en) begin
            se.due  = cyc + 2;
            se.vec  = '0;
            for (int i = 0; i < 8; i++) begin
               if (mvalid[i] && (((mdata[i] ^ o.key) & o.mask) == 4'h0)) se.vec[i] = 1'b1;
            end
            se.addr = '0;
            for (int i = 7; i >= 0; i--) begin
               if (se.vec[i]) se.addr = 3'(i);
            end
            se.m = |se.vec;
            sq.push_back(se);
         end
         if (o.rd_en) begin
            re.due = cyc + 1;
            re.d   = mdata[o.ra];
            re.h   = mvalid[o.ra];
            rq.push_back(re);
         end
         if (o.inv_en) mvalid[o.ia] = 1'b0;
         if (o.wr_en) begin
            mvalid[o.wa] = 1'b1;
            mdata[o.wa]  = o.wd;
         end
      end
   endtask

   always @(negedge CLK) begin
      if (MATCH_VALID === 1'b1) begin
         if (sq.size() == 0) begin
            chk("srch_unexpected", 1, 0);
         end else begin
            sexp_t e;
            e = sq.pop_front();
            chk("srch_latency", cyc, e.due);
            chk("match_vec", MATCH_VEC, e.vec);
            chk("match", MATCH, e.m);
            chk("match_addr", MATCH_ADDR, e.addr);
         end
      end else if (sq.size() > 0 && sq[0].due <= cyc) begin
         chk("srch_missing", 0, 1);
         void'(sq.pop_front());
      end
      if (RD_VALID === 1'b1) begin
         if (rq.size() == 0) begin
            chk("rd_unexpected", 1, 0);
         end else begin
            rexp_t e;
            e = rq.pop_front();
            chk("rd_latency", cyc, e.due);
            chk("rd_data", RD_DATA, e.d);
            chk("rd_hit", RD_HIT, e.h);
         end
      end else if (rq.size() > 0 && rq[0].due <= cyc) begin
         chk("rd_missing", 0, 1);
         void'(rq.pop_front());
      end
   end

   initial begin
      op_t o;
      checks    = 0;
      failures  = 0;
      mvalid    = '0;
      RST       = 1'b1;
      WR_EN     = 1'b0;
      WR_ADDR   = '0;
      WR_DATA   = '0;
      INV_EN    = 1'b0;
      INV_ADDR  = '0;
      RD_EN     = 1'b0;
      RD_ADDR   = '0;
      SRCH_EN   = 1'b0;
      SRCH_KEY  = '0;
      SRCH_MASK = '0;

      o = '0; o.rst = 1'b1;
      issue(o);
      issue(o);
      @(negedge CLK);
      chk("rst_rd_data", RD_DATA, 0);
      chk("rst_rd_hit", RD_HIT, 0);
      chk("rst_rd_valid", RD_VALID, 0);
      chk("rst_match_vec", MATCH_VEC, 0);
      chk("rst_match", MATCH, 0);
      chk("rst_match_addr", MATCH_ADDR, 0);
      chk("rst_match_valid", MATCH_VALID, 0);

      // Empty array: key 0, full mask must miss.
      o = '0; o.s_en = 1'b1; o.key = 4'h0; o.mask = 4'hF;
      issue(o);

      // Fill every entry with 0 while invalidating the previous one,
      // searching with mask 0 every cycle.
      for (int i = 0; i <= 8; i++) begin
         o = '0;
         if (i < 8) begin o.wr_en = 1'b1; o.wa = 3'(i); o.wd = 4'h0; end
         if (i > 0) begin o.inv_en = 1'b1; o.ia = 3'(i - 1); end
         o.s_en = 1'b1; o.mask = 4'h0;
         issue(o);
      end

      o = '0; o.wr_en = 1'b1; o.wa = 3'd3; o.wd = 4'hA; issue(o);
      o = '0; o.wr_en = 1'b1; o.wa = 3'd5; o.wd = 4'hA; issue(o);
      o = '0; o.s_en = 1'b1; o.key = 4'hA; o.mask = 4'hF; issue(o);
      o = '0; o.inv_en = 1'b1; o.ia = 3'd3; issue(o);
      o = '0; o.s_en = 1'b1; o.key = 4'hA; o.mask = 4'hF; issue(o);

      // Ternary compare on entry 1.
      o = '0; o.wr_en = 1'b1; o.wa = 3'd1; o.wd = 4'h6; issue(o);
      o = '0; o.s_en = 1'b1; o.key = 4'hE; o.mask = 4'h7; issue(o);
      o = '0; o.s_en = 1'b1; o.key = 4'hE; o.mask = 4'hF; issue(o);

      // Search during write sees old contents; next search sees the write.
      o = '0; o.wr_en = 1'b1; o.wa = 3'd2; o.wd = 4'h9; o.s_en = 1'b1; o.key = 4'h9; o.mask = 4'hF; issue(o);
      o = '0; o.s_en = 1'b1; o.key = 4'h9; o.mask = 4'hF; issue(o);

      // Write and invalidate the same address: write wins.
      o = '0; o.wr_en = 1'b1; o.wa = 3'd4; o.wd = 4'hC; o.inv_en = 1'b1; o.ia = 3'd4; issue(o);
      o = '0; o.rd_en = 1'b1; o.ra = 3'd4; issue(o);

      // Read during write returns old data; invalid entry reads with hit=0.
      o = '0; o.wr_en = 1'b1; o.wa = 3'd6; o.wd = 4'h3; o.rd_en = 1'b1; o.ra = 3'd6; issue(o);
      o = '0; o.rd_en = 1'b1; o.ra = 3'd6; o.s_en = 1'b1; o.mask = 4'h0; issue(o);
      o = '0; o.rd_en = 1'b1; o.ra = 3'd3; issue(o);
      o = '0; issue(o);

      for (int n = 0; n < 80; n++) begin
         o = op_t'($urandom);
         o.rst = 1'b0;
         issue(o);
      end

      // Three back-to-back searches, reset sampled with the third.
      o = '0; o.s_en = 1'b1; o.key = 4'h0; o.mask = 4'h0; issue(o);
      o = '0; o.s_en = 1'b1; o.key = 4'h1; o.mask = 4'h1; issue(o);
      o = '0; o.rst = 1'b1; o.s_en = 1'b1; o.wr_en = 1'b1; o.wa = 3'd0; o.wd = 4'h5; issue(o);
      o = '0; issue(o);
      @(negedge CLK);
      chk("rst_mid_match_valid", MATCH_VALID, 0);
      chk("rst_mid_match_vec", MATCH_VEC, 0);

      // Everything invalid after reset, including the write issued under reset.
      o = '0; o.s_en = 1'b1; o.mask = 4'h0; o.rd_en = 1'b1; o.ra = 3'd0; issue(o);
      o = '0;
      for (int n = 0; n < 4; n++) issue(o);
      @(negedge CLK);
      chk("sq_drained", sq.size(), 0);
      chk("rq_drained", rq.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
